// File: rtl/matinv_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : matinv_sequencer
// Brief    : Load / compute / unload controller for the 3x3 matrix inverter.
//            Optional MATINV_PERF_CNT_EN adds a busy-cycle counter output.
// Revision : 1.0 - initial release
// ============================================================================
module matinv_sequencer #(
    parameter int DATA_W   = 16,
    parameter int NUM_ELEM = 9,
    parameter int TIMEOUT  = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              sp_start,
    input  logic              sp_done,
    output logic              core_start,
    input  logic              core_done,
    input  logic              core_singular,
    output logic [3:0]        res_sel,
    input  logic [DATA_W-1:0] res_data,
    output logic [7:0]        out_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [1:0]        error
`ifdef MATINV_PERF_CNT_EN
    ,
    output logic [15:0]       perf_cycles
`endif
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_load    = 3'd1;
    localparam logic [2:0] c_st_compute = 3'd2;
    localparam logic [2:0] c_st_unload  = 3'd3;
    localparam logic [2:0] c_st_finish  = 3'd4;

    localparam logic [TMR_W-1:0] c_tmr_last = TMR_W'(TIMEOUT - 1);
    localparam logic [3:0]       c_sel_last = 4'(NUM_ELEM - 1);

    localparam logic [1:0] c_err_ok       = 2'b00;
    localparam logic [1:0] c_err_singular = 2'b01;
    localparam logic [1:0] c_err_load_to  = 2'b10;
    localparam logic [1:0] c_err_comp_to  = 2'b11;

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [TMR_W-1:0] r_timer;
    logic [3:0]       r_sel;
    logic             r_phase_lo;
    logic [1:0]       r_error;
    logic             w_expire;
    logic             w_xfer;
    logic             w_last_byte;

    // The timer restarts at every state entry, so this is the TIMEOUT-th cycle.
    assign w_expire    = (r_timer == c_tmr_last);
    assign w_xfer      = (r_state == c_st_unload) && out_ready;
    assign w_last_byte = w_xfer && r_phase_lo && (r_sel == c_sel_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) w_next_state = c_st_load;
            end
            c_st_load: begin
                if (sp_done)       w_next_state = c_st_compute;
                else if (w_expire) w_next_state = c_st_finish;
            end
            c_st_compute: begin
                if (core_done)     w_next_state = core_singular ? c_st_finish : c_st_unload;
                else if (w_expire) w_next_state = c_st_finish;
            end
            c_st_unload: begin
                if (w_last_byte) w_next_state = c_st_finish;
            end
            c_st_finish: begin
                w_next_state = c_st_idle;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    always_comb begin
        sp_start   = 1'b0;
        core_start = 1'b0;
        out_valid  = 1'b0;
        out_byte   = 8'h00;
        busy       = (r_state != c_st_idle);
        done       = 1'b0;
        case (r_state)
            c_st_load:    sp_start   = 1'b1;
            c_st_compute: core_start = (r_timer == '0);
            c_st_unload: begin
                out_valid = 1'b1;
                out_byte  = r_phase_lo ? res_data[7:0] : res_data[DATA_W-1 -: 8];
            end
            c_st_finish:  done = 1'b1;
            default: ;
        endcase
    end

    assign res_sel = r_sel;
    assign error   = r_error;

    always_ff @(posedge clk) begin
        if (rst || (r_state != w_next_state)) begin
            r_timer <= '0;
        end else if ((r_state == c_st_load) || (r_state == c_st_compute)) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // Element index and byte phase only advance on an accepted byte.
    always_ff @(posedge clk) begin
        if (rst || (r_state != c_st_unload)) begin
            r_sel      <= 4'd0;
            r_phase_lo <= 1'b0;
        end else if (w_xfer) begin
            if (!r_phase_lo) begin
                r_phase_lo <= 1'b1;
            end else begin
                r_phase_lo <= 1'b0;
                r_sel      <= (r_sel == c_sel_last) ? 4'd0 : r_sel + 4'd1;
            end
        end
    end

    // Error is sticky across IDLE so software can read it after done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_error <= c_err_ok;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) r_error <= c_err_ok;
                end
                c_st_load: begin
                    if (!sp_done && w_expire) r_error <= c_err_load_to;
                end
                c_st_compute: begin
                    if (core_done && core_singular) r_error <= c_err_singular;
                    else if (!core_done && w_expire) r_error <= c_err_comp_to;
                end
                default: ;
            endcase
        end
    end

`ifdef MATINV_PERF_CNT_EN
    logic [15:0] r_perf_cnt;
    logic [15:0] r_perf_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_cnt <= 16'h0000;
            r_perf_out <= 16'h0000;
        end else begin
            if ((r_state == c_st_idle) && start) begin
                r_perf_cnt <= 16'h0000;
            end else if ((r_state != c_st_idle) && (r_perf_cnt != 16'hFFFF)) begin
                r_perf_cnt <= r_perf_cnt + 16'h0001;
            end
            // Captured count includes the FINISH cycle itself.
            if (r_state == c_st_finish) begin
                r_perf_out <= (r_perf_cnt == 16'hFFFF) ? 16'hFFFF : r_perf_cnt + 16'h0001;
            end
        end
    end

    assign perf_cycles = r_perf_out;
`endif

endmodule
`default_nettype wire

// File: tb/tb_matinv_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_matinv_sequencer
// Brief    : Directed and randomized run-level checks of matinv_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matinv_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sp_start;
    logic        sp_done;
    logic        core_start;
    logic        core_done;
    logic        core_singular;
    logic [3:0]  res_sel;
    logic [15:0] res_data;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic [1:0]  error;
`ifdef MATINV_PERF_CNT_EN
    logic [15:0] perf_cycles;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] elem [9];

    // Environment model of the core output mux.
    assign res_data = (res_sel < 4'd9) ? elem[res_sel] : 16'hDEAD;

    matinv_sequencer #(
        .DATA_W   (16),
        .NUM_ELEM (9),
        .TIMEOUT  (1023)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .sp_start      (sp_start),
        .sp_done       (sp_done),
        .core_start    (core_start),
        .core_done     (core_done),
        .core_singular (core_singular),
        .res_sel       (res_sel),
        .res_data      (res_data),
        .out_byte      (out_byte),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .done          (done),
        .error         (error)
`ifdef MATINV_PERF_CNT_EN
        ,
        .perf_cycles   (perf_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running observation counters; runs compare differences.
    int         n_sp = 0, n_cs = 0, n_done = 0, n_busy = 0, n_valid = 0;
    int         n_stall_bad = 0, n_sel_bad = 0;
    logic [7:0] got_q [$];
    bit         stall_prev = 1'b0;
    logic [7:0] prev_byte;
    logic [3:0] prev_sel;

    always @(negedge clk) begin
        if (sp_start)   n_sp++;
        if (core_start) n_cs++;
        if (done)       n_done++;
        if (busy)       n_busy++;
        if (out_valid)  n_valid++;
        if (out_valid && out_ready) got_q.push_back(out_byte);
        if (stall_prev && out_valid && ((out_byte !== prev_byte) || (res_sel !== prev_sel)))
            n_stall_bad++;
        if (res_sel > 4'd8) n_sel_bad++;
        stall_prev = out_valid && !out_ready && !rst;
        prev_byte  = out_byte;
        prev_sel   = res_sel;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_sp_start"},   32'(sp_start),   32'd0);
        chk({tag, "_core_start"}, 32'(core_start), 32'd0);
        chk({tag, "_res_sel"},    32'(res_sel),    32'd0);
        chk({tag, "_out_byte"},   32'(out_byte),   32'd0);
        chk({tag, "_out_valid"},  32'(out_valid),  32'd0);
        chk({tag, "_busy"},       32'(busy),       32'd0);
        chk({tag, "_done"},       32'(done),       32'd0);
        chk({tag, "_error"},      32'(error),      32'd0);
    endtask

    // L/C: cycles until sp_done/core_done (0 = never). rmode: 0 always ready,
    // 1 pattern 1,0,0,1, 2 random. rst_at >= 0 resets after that many bytes.
    task automatic run(input int L, input int C, input bit sing, input int rmode,
                       input bit noisy, input int rst_at, input string tag);
        int         b_sp, b_cs, b_done, b_busy, b_valid, b_stall, b_sel, b_got;
        int         ld, cd, k, n, ones, lc, cc, uc, e_busy, e_cs, e_bytes, ng;
        logic [1:0] e_err;
        bit         cd_on, fin, aborted, load_to, comp_to;
        bit         rq [$];
        logic [7:0] exp_q [$];

        ones = 0;
        for (int i = 0; ones < 18; i++) begin
            bit r;
            case (rmode)
                0:       r = 1'b1;
                1:       r = ((i % 4) == 0) || ((i % 4) == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            rq.push_back(r);
            if (r) ones++;
        end
        uc = rq.size();
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(elem[i][15:8]);
            exp_q.push_back(elem[i][7:0]);
        end

        load_to = !(L >= 1 && L <= 1023);
        lc      = load_to ? 1023 : L;
        comp_to = !(C >= 1 && C <= 1023);
        cc      = comp_to ? 1023 : C;
        e_cs    = load_to ? 0 : 1;
        e_bytes = 0;
        if (load_to) begin
            e_busy = lc + 1; e_err = 2'b10;
        end else if (comp_to) begin
            e_busy = lc + cc + 1; e_err = 2'b11;
        end else if (sing) begin
            e_busy = lc + cc + 1; e_err = 2'b01;
        end else begin
            e_busy = lc + cc + uc + 1; e_err = 2'b00; e_bytes = 18;
        end

        b_sp = n_sp; b_cs = n_cs; b_done = n_done; b_busy = n_busy; b_valid = n_valid;
        b_stall = n_stall_bad; b_sel = n_sel_bad; b_got = got_q.size();

        core_singular = sing;
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_err_cleared"}, 32'(error),    32'd0);
        chk({tag, "_load_entry"},  32'(sp_start), 32'd1);

        ld = 0; cd = 0; k = 0; n = 0; cd_on = 0; fin = 0; aborted = 0;
        while (!fin && n < 4000) begin
            start = 1'b0; sp_done = 1'b0; core_done = 1'b0; out_ready = 1'b0;
            if (done) begin
                fin = 1;
            end else if (rst_at >= 0 && out_valid && (got_q.size() - b_got) == rst_at) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                chk_idle_zero({tag, "_midrst"});
                fin = 1; aborted = 1;
            end else begin
                if (noisy) start = 1'($urandom_range(0, 1));
                if (sp_start) begin
                    sp_done = (L != 0) && (ld == L - 1);
                    ld++;
                end
                if (core_start) cd_on = 1;
                if (cd_on) begin
                    core_done = (C != 0) && (cd == C - 1);
                    cd++;
                    if (core_done) cd_on = 0;
                end
                if (out_valid) begin
                    out_ready = (k < rq.size()) ? rq[k] : 1'b1;
                    k++;
                end
                step();
                n++;
            end
        end
        chk({tag, "_finished"}, 32'(fin), 32'd1);
        if (!aborted) begin
            start = 1'b0; out_ready = 1'b0;
            step();
            chk({tag, "_idle_busy"},   32'(busy),                  32'd0);
            chk({tag, "_done_count"},  32'(n_done - b_done),       32'd1);
            chk({tag, "_busy_cycles"}, 32'(n_busy - b_busy),       32'(e_busy));
            chk({tag, "_sp_cycles"},   32'(n_sp - b_sp),           32'(lc));
            chk({tag, "_core_starts"}, 32'(n_cs - b_cs),           32'(e_cs));
            chk({tag, "_valid_cyc"},   32'(n_valid - b_valid),     32'(e_bytes == 0 ? 0 : uc));
            chk({tag, "_stall_bad"},   32'(n_stall_bad - b_stall), 32'd0);
            chk({tag, "_sel_range"},   32'(n_sel_bad - b_sel),     32'd0);
            chk({tag, "_error"},       32'(error),                 32'(e_err));
            ng = got_q.size() - b_got;
            chk({tag, "_byte_count"},  32'(ng),                    32'(e_bytes));
            for (int i = 0; i < ng && i < e_bytes; i++)
                chk($sformatf("%s_byte%0d", tag, i), 32'(got_q[b_got + i]), 32'(exp_q[i]));
            step(); step(); step();
            chk({tag, "_err_sticky"},  32'(error),                 32'(e_err));
            chk({tag, "_no_requeue"},  32'(busy),                  32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sp_done = 1'b0; core_done = 1'b0;
        core_singular = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 9; i++) elem[i] = 16'h1000 + 16'(i);
        step(); step();
        chk_idle_zero("reset");
        rst = 1'b0;
        step();

        run(20, 5, 1'b0, 0, 1'b0, -1, "nominal");
        run(20, 5, 1'b0, 1, 1'b0, -1, "backpressure");

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 9; i++) elem[i] = 16'($urandom);
            run($urandom_range(1, 40), $urandom_range(1, 20), 1'b0, 2, 1'b1, -1,
                $sformatf("rand%0d", r));
        end

        run($urandom_range(1, 30), $urandom_range(1, 10), 1'b1, 0, 1'b1, -1, "singular");
        run(0, 5, 1'b0, 0, 1'b0, -1, "load_timeout");
        run(10, 0, 1'b0, 0, 1'b0, -1, "comp_timeout");
        for (int i = 0; i < 9; i++) elem[i] = 16'($urandom);
        run(1023, 3, 1'b0, 2, 1'b0, -1, "expiry_edge");

        run(8, 4, 1'b0, 2, 1'b0, 7, "mid_reset");
        step();
        for (int i = 0; i < 9; i++) elem[i] = 16'($urandom);
        run(12, 3, 1'b0, 0, 1'b0, -1, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matinv_sequencer.md
Name: matinv_sequencer

Overview:
- Top-level controller for the 3x3 matrix-inversion datapath.
- Sequences three stages:
  - loading the 18-byte operand stream through serial_parallel_interface;
  - starting the inversion core and waiting for it;
  - serialising the nine 16-bit result elements back out as bytes with a valid/ready handshake.
- Reports completion, singular-matrix errors and stage timeouts.

Parameters:
- DATA_W, 16: width of one matrix element. Must be 16 for the byte serialiser.
- NUM_ELEM, 9: result elements to unload.
- TIMEOUT, 1023: maximum cycles allowed in LOAD or COMPUTE before abort.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  request a run; sampled only in IDLE
- sp_start  out  1  level enable to serial_parallel_interface
- sp_done  in  1  operand load complete
- core_start  out  1  one-cycle pulse to inversion core
- core_done  in  1  inversion result valid (level or pulse)
- core_singular  in  1  determinant zero; sampled with core_done
- res_sel  out  4  result element index to the core output mux
- res_data  in  DATA_W  selected result element
- out_byte  out  8  serialised result byte
- out_valid  out  1  out_byte valid
- out_ready  in  1  downstream accepts byte
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of run
- error  out  2  00 ok, 01 singular, 10 load timeout, 11 compute timeout

Behaviour:
- Reset: synchronous, active-high, applied on the clk edge. Returns to IDLE from any state, including mid-run.
  - All outputs 0: sp_start, core_start, res_sel, out_byte, out_valid, busy, done, error.
  - Internal counters cleared.
- States: IDLE, LOAD, COMPUTE, UNLOAD, FINISH.
- IDLE:
  - start=1 → LOAD on the next edge; error cleared to 00 and timeout counter cleared.
  - error is otherwise sticky from the previous run.
- LOAD:
  - sp_start held 1 for the whole state.
  - sp_done=1 → COMPUTE; sp_start drops on the same edge.
  - Timeout counter reaches TIMEOUT → FINISH, error=10.
- COMPUTE:
  - core_start=1 only in the first cycle of the state.
  - core_done=1 with core_singular=1 → FINISH, error=01; UNLOAD is skipped.
  - core_done=1 with core_singular=0 → UNLOAD with res_sel=0 and byte phase=high.
  - Timeout counter reaches TIMEOUT → FINISH, error=11.
- Timeout counter:
  - Reset on every state entry.
  - Increments each cycle in LOAD and COMPUTE.
  - If done and expiry occur in the same cycle, done wins.
- UNLOAD:
  - out_valid=1 throughout.
  - out_byte = res_data[15:8] in the high phase, res_data[7:0] in the low phase, combinational from res_data.
  - Byte transfer occurs only on out_valid && out_ready.
    - High phase: transfer → low phase.
    - Low phase: transfer → res_sel+1, high phase.
  - out_ready=0 holds res_sel, phase and out_byte stable.
  - Transfer of the low byte at res_sel=NUM_ELEM-1 → FINISH; out_valid=0 from that edge.
  - Minimum unload time is 2*NUM_ELEM = 18 cycles.
- FINISH:
  - done=1 for exactly one cycle, then IDLE.
  - busy stays 1 in FINISH.
- Single-run latency with out_ready=1 and no stalls: LOAD + COMPUTE + 18 + 1 cycles.
- start while busy is ignored; it is not queued.
- res_sel never exceeds NUM_ELEM-1; it is held at 0 outside UNLOAD.

Optional Feature:
- Macro: MATINV_PERF_CNT_EN.
- Defined:
  - Adds output perf_cycles [15:0].
  - Internal counter cleared on accepted start; increments every busy cycle, saturating at 16'hFFFF.
  - perf_cycles updates with the final count in the FINISH cycle and holds until the next FINISH.
  - Reset value 0.
- Not defined: no port, no counter logic.

Test Plan:
- Nominal run:
  - Stimulus: rst 2 cycles; start; sp_done after 20 cycles; core_done after 5 cycles; res_data = 16'h1000+res_sel; out_ready=1.
  - Required: sp_start high for exactly 20 cycles; one core_start pulse; 18 bytes 10,00,10,01,...,10,08 on 18 consecutive cycles; single done pulse; error=00.
- Backpressure:
  - Stimulus: same as nominal, with out_ready toggling 1,0,0,1.
  - Required: out_byte/res_sel stable while out_ready=0; exact same 18-byte sequence; no byte duplicated or dropped.
- Singular:
  - Stimulus: core_done=1 with core_singular=1.
  - Required: out_valid never asserted; done pulse the next cycle; error=01 held until the next start.
- Timeouts:
  - Stimulus A: sp_done never asserted. Required: FINISH after 1023 LOAD cycles, error=10.
  - Stimulus B: load completes, core_done never asserted. Required: error=11.
  - Stimulus C: sp_done on exactly the expiry cycle. Required: normal progression.
- Start while busy: start pulses during COMPUTE and UNLOAD → no effect; exactly one done per accepted start.
- Reset mid-UNLOAD:
  - Stimulus: rst during byte 7.
  - Required: next edge all outputs 0, busy=0; a fresh start then yields a full 18-byte run from res_sel=0.
